// File: rtl/ysyx_2022040010_if.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem request, FIFO toward decode.
// Define YSYX_IF_PERF_CNT_EN to add fetch/stall/flush performance counters.
module ysyx_2022040010_if #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
`ifdef YSYX_IF_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt,
    output logic [63:0] perf_flush_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [63:0]   req_pc;
    logic [63:0]   buf_pc   [FIFO_DEPTH];
    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic req_hs;
    logic push;
    logic pop;

    // Requests only go out when a FIFO slot is free for the response.
    assign imem_req_valid = rst & (state == S_RUN) & (count < FULL);
    assign imem_req_addr  = rst ? pc : '0;
    assign req_hs         = imem_req_valid & imem_req_ready;

    assign push = (state == S_WAIT) & imem_resp_valid & ~redirect_valid;
    assign pop  = id_valid & id_ready & ~redirect_valid;

    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? buf_pc[rd_ptr]   : '0;
    assign id_inst  = id_valid ? buf_inst[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_RUN;
            pc     <= RESET_PC;
            req_pc <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc & ~64'd3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            unique case (state)
                S_RUN:   state <= req_hs ? S_DISCARD : S_RUN;
                S_WAIT,
                S_DISCARD: state <= imem_resp_valid ? S_RUN : S_DISCARD;
                default: state <= S_RUN;
            endcase
        end else begin
            unique case (state)
                S_RUN: begin
                    if (req_hs) begin
                        pc     <= pc + 64'd4;
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT:    if (imem_resp_valid) state <= S_RUN;
                S_DISCARD: if (imem_resp_valid) state <= S_RUN;
                default:   state <= S_RUN;
            endcase
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= req_pc;
            buf_inst[wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            assert (count < FULL)
            else $error("ysyx_2022040010_if: push into full FIFO");
        end
    end

`ifdef YSYX_IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (!id_valid && (state != S_RUN ||
                (imem_req_valid && !imem_req_ready)))
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_2022040010_if.sv
// Bench for ysyx_2022040010_if: directed vector table, async reset, then
// random traffic against a program-order fetch model.
module tb_ysyx_2022040010_if;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ysyx_2022040010_if dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic        idr;
        logic        rdr;
        logic [63:0] rpc;
        logic        ev;
        logic [63:0] ea;
        logic        iv;
        logic [63:0] ip;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mem_addr = '0;
    vec_t        v [30];

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(
        input logic rdy, input logic rsp, input logic idr, input logic rdr,
        input logic [11:0] ro, input logic ev, input logic [11:0] ea,
        input logic iv, input logic [11:0] ip);
        vec_t t;
        t.rdy = rdy; t.rsp = rsp; t.idr = idr; t.rdr = rdr;
        t.rpc = BASE + 64'(ro);
        t.ev  = ev;  t.ea  = BASE + 64'(ea);
        t.iv  = iv;  t.ip  = BASE + 64'(ip);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, advance to posedge+1.
    task automatic apply(input vec_t t, input int idx);
        imem_req_ready  = t.rdy;
        imem_resp_valid = t.rsp;
        imem_resp_data  = t.rsp ? word(mem_addr) : '0;
        id_ready        = t.idr;
        redirect_valid  = t.rdr;
        redirect_pc     = t.rpc;
        @(negedge clk);
        chk($sformatf("v%0d req_valid", idx), imem_req_valid, t.ev);
        if (t.ev) chk($sformatf("v%0d req_addr", idx), imem_req_addr, t.ea);
        chk($sformatf("v%0d id_valid", idx), id_valid, t.iv);
        chk($sformatf("v%0d id_pc", idx), id_pc, t.iv ? t.ip : 64'd0);
        chk($sformatf("v%0d id_inst", idx), id_inst,
            t.iv ? 64'(word(t.ip)) : 64'd0);
        if (imem_req_valid && imem_req_ready) mem_addr = imem_req_addr;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] fetch_pc;
    logic [63:0] exp_pc;
    logic [63:0] tgt;
    logic        rdr;
    bit          busy;
    int          dly;
    int          pops;

    initial begin
        // rdy rsp idr rdr roff  ev  addr  iv  pc
        v[0]  = mk(1, 0, 1, 0, 12'h000, 1, 12'h000, 0, 12'h000);
        v[1]  = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[2]  = mk(1, 0, 1, 0, 12'h000, 1, 12'h004, 1, 12'h000);
        v[3]  = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[4]  = mk(1, 0, 1, 0, 12'h000, 1, 12'h008, 1, 12'h004);
        v[5]  = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[6]  = mk(1, 0, 0, 0, 12'h000, 1, 12'h00C, 1, 12'h008);
        v[7]  = mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h008);
        v[8]  = mk(1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 12'h008);
        v[9]  = mk(1, 0, 0, 0, 12'h000, 0, 12'h000, 1, 12'h008);
        v[10] = mk(1, 0, 1, 0, 12'h000, 0, 12'h000, 1, 12'h008);
        v[11] = mk(1, 0, 1, 0, 12'h000, 1, 12'h010, 1, 12'h00C);
        v[12] = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[13] = mk(1, 0, 1, 0, 12'h000, 1, 12'h014, 1, 12'h010);
        v[14] = mk(1, 0, 1, 1, 12'h102, 0, 12'h000, 0, 12'h000);
        v[15] = mk(1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[16] = mk(1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[17] = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[18] = mk(1, 0, 1, 0, 12'h000, 1, 12'h100, 0, 12'h000);
        v[19] = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[20] = mk(1, 0, 0, 0, 12'h000, 1, 12'h104, 1, 12'h100);
        v[21] = mk(1, 1, 1, 1, 12'h200, 0, 12'h000, 1, 12'h100);
        for (int i = 22; i < 27; i++)
            v[i] = mk(0, 0, 1, 0, 12'h000, 1, 12'h200, 0, 12'h000);
        v[27] = mk(1, 0, 1, 0, 12'h000, 1, 12'h200, 0, 12'h000);
        v[28] = mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        v[29] = mk(0, 0, 1, 0, 12'h000, 1, 12'h204, 1, 12'h200);

        @(negedge clk);
        chk("reset req_valid", imem_req_valid, 1'b0);
        chk("reset id_valid", id_valid, 1'b0);
        chk("reset id_pc", id_pc, 64'd0);
        chk("reset id_inst", id_inst, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 30; i++) apply(v[i], i);

        // Fill one entry, launch another request, then reset while in WAIT.
        apply(mk(1, 0, 0, 0, 12'h000, 1, 12'h204, 0, 12'h000), 30);
        apply(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000), 31);
        apply(mk(1, 0, 0, 0, 12'h000, 1, 12'h208, 1, 12'h204), 32);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async rst req_valid", imem_req_valid, 1'b0);
        chk("async rst req_addr", imem_req_addr, 64'd0);
        chk("async rst id_valid", id_valid, 1'b0);
        chk("async rst id_pc", id_pc, 64'd0);
        chk("async rst id_inst", id_inst, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("post-rst req_valid", imem_req_valid, 1'b1);
        chk("post-rst req_addr", imem_req_addr, BASE);

        // Random traffic: decode must see program order from the last redirect.
        fetch_pc = BASE;
        exp_pc   = BASE;
        busy     = 1'b0;
        dly      = 0;
        pops     = 0;
        for (int i = 0; i < 3000; i++) begin
            rdr = ($urandom_range(0, 15) == 0);
            tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFF)};
            imem_req_ready  = ($urandom_range(0, 3) != 0);
            id_ready        = ($urandom_range(0, 3) != 0);
            imem_resp_valid = busy && (dly == 0);
            imem_resp_data  = imem_resp_valid ? word(mem_addr) : '0;
            redirect_valid  = rdr;
            redirect_pc     = tgt;
            @(negedge clk);
            if (!id_valid) chk("rand idle id_inst", id_inst, 64'd0);
            if (imem_req_valid) begin
                chk("rand one outstanding", 64'(busy), 64'd0);
                chk("rand req_addr", imem_req_addr, fetch_pc);
            end
            if (id_valid && id_ready && !rdr) begin
                chk("rand id_pc", id_pc, exp_pc);
                chk("rand id_inst", id_inst, 64'(word(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (imem_resp_valid) busy = 1'b0;
            else if (busy && dly > 0) dly--;
            if (imem_req_valid && imem_req_ready) begin
                busy     = 1'b1;
                dly      = $urandom_range(0, 3);
                mem_addr = imem_req_addr;
                fetch_pc = fetch_pc + 64'd4;
            end
            if (rdr) begin
                fetch_pc = tgt & ~64'd3;
                exp_pc   = fetch_pc;
            end
            @(posedge clk);
            #1;
        end
        chk("rand progress", 64'(pops >= 150), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
